// File: rtl/ram_master_pkg.sv
// Shared types and default sizing for the ram_master burst RAM controller.
package ram_master_pkg;

  localparam int unsigned DEF_ADDR_SIZE   = 10;
  localparam int unsigned DEF_WORD_SIZE   = 8;
  localparam int unsigned DEF_WAIT_STATES = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

endpackage

// File: rtl/ram_master.sv
// Burst RAM master: accepts a read/write command of 1..16 beats and drives a
// synchronous RAM with a SETUP phase followed by WAIT_STATES+1 ACCESS cycles per beat.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int unsigned ADDR_SIZE   = DEF_ADDR_SIZE,
  parameter int unsigned WORD_SIZE   = DEF_WORD_SIZE,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [3:0]           req_len,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic                 rdata_valid,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 ram_cs,
  output logic                 ram_wr,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  input  logic [WORD_SIZE-1:0] ram_rdata,
  output logic                 busy
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_e                 state_q;
  logic                   wr_q;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [ADDR_SIZE-1:0]   addr_d;
  logic [WORD_SIZE-1:0]   wdata_q;
  logic [WORD_SIZE-1:0]   rdata_q;
  logic                   rdata_valid_q;
  logic [3:0]             beats_q;
  logic [3:0]             wait_q;

  // Natural wrap of the adder gives the modulo-2^ADDR_SIZE beat address.
  assign addr_d = addr_q + {{(ADDR_SIZE-1){1'b0}}, 1'b1};

  // Control strobes decode directly from registered state so reset clears them at once.
  assign busy        = (state_q != ST_IDLE);
  assign req_ready   = (state_q == ST_IDLE) && !rst;
  assign wdata_ready = (state_q == ST_SETUP) && wr_q;
  assign ram_cs      = (state_q != ST_IDLE);
  assign ram_wr      = (state_q == ST_ACCESS) && wr_q;
  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

  // Controller FSM with its beat/wait counters and data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      beats_q       <= 4'd0;
      wait_q        <= 4'd0;
    end else begin
      rdata_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr;
            beats_q <= req_len;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (!wr_q) begin
            wait_q  <= WAIT_INIT;
            state_q <= ST_ACCESS;
          end else if (wdata_valid) begin
            wdata_q <= wdata;
            wait_q  <= WAIT_INIT;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (wait_q == 4'd0) begin
            if (!wr_q) begin
              rdata_q       <= ram_rdata;
              rdata_valid_q <= 1'b1;
            end
            if (beats_q == 4'd0) begin
              state_q <= ST_IDLE;
            end else begin
              beats_q <= beats_q - 4'd1;
              addr_q  <= addr_d;
              state_q <= ST_SETUP;
            end
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master: one instance with one wait state, one with none,
// both reading from a shared behavioural RAM preloaded with addr[7:0]^0x5A.
module tb_ram_master;

  logic       clk;
  logic       rst;
  logic       req_valid, req_wr, wdata_valid;
  logic [9:0] req_addr;
  logic [3:0] req_len;
  logic [7:0] wdata;
  logic       req_ready, wdata_ready, rdata_valid, ram_cs, ram_wr, busy;
  logic [7:0] rdata, ram_wdata, ram_rdata;
  logic [9:0] ram_addr;

  logic       req_valid1;
  logic [9:0] req_addr1;
  logic       req_ready1, wdata_ready1, rdata_valid1, ram_cs1, ram_wr1, busy1;
  logic [7:0] rdata1, ram_wdata1, ram_rdata1;
  logic [9:0] ram_addr1;

  logic [7:0] mem [0:1023];
  logic [9:0] exp_addr [4];
  logic [7:0] exp_data [4];

  int checks = 0;
  int errors = 0;
  int n;
  int pulses;
  int cs_cnt;

  ram_master #(.ADDR_SIZE(10), .WORD_SIZE(8), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata),
    .ram_cs(ram_cs), .ram_wr(ram_wr), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  ram_master #(.ADDR_SIZE(10), .WORD_SIZE(8), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_wr(1'b0),
    .req_addr(req_addr1), .req_len(4'd0),
    .wdata_valid(1'b0), .wdata_ready(wdata_ready1), .wdata(8'd0),
    .rdata_valid(rdata_valid1), .rdata(rdata1),
    .ram_cs(ram_cs1), .ram_wr(ram_wr1), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: preloaded during reset, written by the WS=1 master only.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (ram_cs && ram_wr) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  assign ram_rdata  = mem[ram_addr];
  assign ram_rdata1 = mem[ram_addr1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 10'd0; req_len = 4'd0;
    wdata_valid = 1'b0; wdata = 8'd0; req_valid1 = 1'b0; req_addr1 = 10'd0;
    exp_addr[0] = 10'h3FE; exp_addr[1] = 10'h3FF; exp_addr[2] = 10'h000; exp_addr[3] = 10'h001;
    exp_data[0] = 8'hA4;   exp_data[1] = 8'hA5;   exp_data[2] = 8'h5A;   exp_data[3] = 8'h5B;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_ram_cs", 32'(ram_cs), 32'd0);
    check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_req_ready", 32'(req_ready), 32'd1);

    // Single write 0x005 <- 0xA5
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h005; req_len = 4'd0;
    tick();
    req_valid = 1'b0;
    check("wr_setup_busy", 32'(busy), 32'd1);
    check("wr_setup_cs", 32'(ram_cs), 32'd1);
    check("wr_setup_wr", 32'(ram_wr), 32'd0);
    check("wr_setup_wready", 32'(wdata_ready), 32'd1);
    check("wr_setup_addr", 32'(ram_addr), 32'h005);
    check("wr_setup_rready", 32'(req_ready), 32'd0);
    wdata_valid = 1'b1; wdata = 8'hA5;
    tick();
    wdata_valid = 1'b0; wdata = 8'h00;
    check("wr_acc1_wr", 32'(ram_wr), 32'd1);
    check("wr_acc1_wdata", 32'(ram_wdata), 32'hA5);
    check("wr_acc1_wready", 32'(wdata_ready), 32'd0);
    tick();
    check("wr_acc2_wr", 32'(ram_wr), 32'd1);
    check("wr_acc2_addr", 32'(ram_addr), 32'h005);
    tick();
    check("wr_done_wr", 32'(ram_wr), 32'd0);
    check("wr_done_cs", 32'(ram_cs), 32'd0);
    check("wr_done_busy", 32'(busy), 32'd0);
    check("wr_hold_wdata", 32'(ram_wdata), 32'hA5);
    check("wr_hold_addr", 32'(ram_addr), 32'h005);

    // Read back 0x005: valid in cycle 4 counting the handshake cycle as 0
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'h005; req_len = 4'd0;
    tick();
    req_valid = 1'b0;
    n = 1;
    while (!rdata_valid && n < 20) begin tick(); n++; end
    check("rd_latency", 32'(n), 32'd4);
    check("rd_data", 32'(rdata), 32'hA5);
    tick();
    check("rd_pulse_end", 32'(rdata_valid), 32'd0);
    check("rd_hold", 32'(rdata), 32'hA5);

    // Read burst 0x3FE, 4 beats, crossing the address wrap
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'h3FE; req_len = 4'd3;
    tick();
    req_valid = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 13; c++) begin
      if (c % 3 == 1 && c <= 10) check("burst_addr", 32'(ram_addr), 32'(exp_addr[(c-1)/3]));
      if (c % 3 == 1 && c >= 4) begin
        check("burst_valid", 32'(rdata_valid), 32'd1);
        check("burst_data", 32'(rdata), 32'(exp_data[(c-4)/3]));
      end
      pulses += int'(rdata_valid);
      if (c < 13) tick();
    end
    check("burst_pulses", 32'(pulses), 32'd4);
    check("burst_idle", 32'(busy), 32'd0);

    // Write with write data held back for 5 cycles
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h010; req_len = 4'd0;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("dly_cs", 32'(ram_cs), 32'd1);
      check("dly_wr", 32'(ram_wr), 32'd0);
      tick();
    end
    check("dly_still_setup", 32'(wdata_ready), 32'd1);
    wdata_valid = 1'b1; wdata = 8'h3C;
    tick();
    wdata_valid = 1'b0;
    check("dly_wr_rise", 32'(ram_wr), 32'd1);
    check("dly_wdata", 32'(ram_wdata), 32'h3C);
    repeat (2) tick();
    check("dly_mem", 32'(mem[10'h010]), 32'h3C);

    // Reset during write ACCESS of a 2-beat burst
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h020; req_len = 4'd1;
    wdata_valid = 1'b1; wdata = 8'h77;
    tick();
    req_valid = 1'b0;
    tick();
    wdata_valid = 1'b0;
    check("mid_wr_active", 32'(ram_wr), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_cs", 32'(ram_cs), 32'd0);
    check("mid_rst_wr", 32'(ram_wr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rready", 32'(req_ready), 32'd0);
    check("mid_rst_addr", 32'(ram_addr), 32'd0);
    check("mid_rst_wdata", 32'(ram_wdata), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rel_rready", 32'(req_ready), 32'd1);
    cs_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      cs_cnt += int'(ram_cs) + int'(rdata_valid);
    end
    check("mid_no_access", 32'(cs_cnt), 32'd0);

    // req_valid held high through a 2-beat read
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'h100; req_len = 4'd1;
    tick();
    req_addr = 10'h200; req_len = 4'd0;
    for (int c = 1; c <= 6; c++) begin
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_rready", 32'(req_ready), 32'd0);
      tick();
    end
    check("hold_idle_busy", 32'(busy), 32'd0);
    check("hold_idle_rready", 32'(req_ready), 32'd1);
    check("hold_last_valid", 32'(rdata_valid), 32'd1);
    check("hold_last_data", 32'(rdata), 32'h5B);
    tick();
    req_valid = 1'b0;
    check("hold_second_busy", 32'(busy), 32'd1);
    check("hold_second_addr", 32'(ram_addr), 32'h200);
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    check("hold_second_done", 32'(busy), 32'd0);

    // Zero wait states: single read of 0x0AB
    req_valid1 = 1'b1; req_addr1 = 10'h0AB;
    tick();
    req_valid1 = 1'b0;
    n = 1;
    cs_cnt = 0;
    while (!rdata_valid1 && n < 20) begin
      cs_cnt += int'(ram_cs1);
      tick();
      n++;
    end
    check("ws0_latency", 32'(n), 32'd3);
    check("ws0_cs_cycles", 32'(cs_cnt), 32'd2);
    check("ws0_data", 32'(rdata1), 32'hF1);
    check("ws0_idle", 32'(busy1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
